// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative 32-bit multiply/divide unit with HI/LO write-back and pipeline stall control
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  ALU2Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        RHLRd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        HLWr,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_cnt;
  logic [63:0] r_acc;      // multiply: product accumulator; divide: remainder:quotient
  logic [31:0] r_b;        // |B| (or raw B for unsigned ops)
  logic [31:0] r_a_raw;    // raw A, returned as HI on divide-by-zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div;
  logic        r_neg_q;    // product / quotient sign
  logic        r_neg_r;    // remainder sign
  logic        r_dz;

  logic        w_accept;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_a_neg  = ALU2Op[0] & A[31];
  assign w_b_neg  = ALU2Op[0] & B[31];
  assign w_abs_a  = w_a_neg ? (~A + 32'd1) : A;
  assign w_abs_b  = w_b_neg ? (~B + 32'd1) : B;

  // One radix-2 step: add-and-shift for multiply, restoring subtract-and-shift for divide.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
  assign w_div_ge   = (r_acc[63:31] >= {1'b0, r_b});
  assign w_div_diff = r_acc[62:31] - r_b;
  assign w_acc_next = r_div ? (w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                        : {r_acc[62:0], 1'b0})
                            : {w_mul_sum, r_acc[31:1]};

  assign w_prod = r_neg_q ? (~w_acc_next + 64'd1) : w_acc_next;
  assign w_q    = r_neg_q ? (~w_acc_next[31:0] + 32'd1) : w_acc_next[31:0];
  assign w_r    = r_neg_r ? (~w_acc_next[63:32] + 32'd1) : w_acc_next[63:32];

  // Sign-corrected final result; divide-by-zero bypasses correction and returns raw A.
  always_comb begin
    w_hi_res = w_prod[63:32];
    w_lo_res = w_prod[31:0];
    if (r_div) begin
      if (r_dz) begin
        w_hi_res = r_a_raw;
        w_lo_res = 32'hFFFF_FFFF;
      end else begin
        w_hi_res = w_r;
        w_lo_res = w_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and control outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    HLWr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)                 w_state_next = S_IDLE;
        else if (r_cnt == 6'd31)   w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        HLWr         = !flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    stall = busy & (RHLRd | start);
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 6'd0;
      r_acc   <= 64'd0;
      r_b     <= 32'd0;
      r_a_raw <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 6'd0;
            r_acc   <= {32'd0, w_abs_a};
            r_b     <= w_abs_b;
            r_a_raw <= A;
            r_div   <= ALU2Op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (B == 32'd0);
          end
        end
        S_CALC: begin
          if (flush) begin
            r_cnt <= 6'd0;
          end else begin
            r_acc <= w_acc_next;
            if (r_cnt == 6'd31) begin
              r_cnt <= 6'd0;
              r_hi  <= w_hi_res;
              r_lo  <= w_lo_res;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard testbench for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  ALU2Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        RHLRd;
  logic        busy;
  logic        stall;
  logic        done;
  logic        HLWr;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb_q[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  logic [1:0]  v_op [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
  logic [31:0] v_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100,
                            32'h80000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] v_b  [8] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0,
                            32'hFFFFFFFF, 32'd0, 32'd7, 32'h80000000};
  bit          v_fad[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  mdu_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALU2Op (ALU2Op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .RHLRd  (RHLRd),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .HLWr   (HLWr),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = sa * sb;
      2'd2: p = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    ALU2Op = op;
    A      = a;
    B      = b;
  endtask

  task automatic wait_done(input bit fad, output int lat, output int nbusy,
                           output logic [31:0] hi, output logic [31:0] lo, output logic hl);
    lat = 0; nbusy = 0; hi = 32'd0; lo = 32'd0; hl = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (done && fad) flush = 1'b1;
      #1;
      if (busy) nbusy++;
      if (done) begin
        lat = n; hi = HI; lo = LO; hl = HLWr;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset;
    int lat, nb; logic [31:0] hi, lo; logic hl; logic [63:0] exp;
    rst = 1'b0; flush = 1'b0; RHLRd = 1'b1;
    issue(2'd0, 32'd3, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (HLWr !== 1'b0)   begin errors++; $display("FAIL reset_hlwr got %b want 0", HLWr); end
    checks++; if (HI !== 32'd0)    begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
    checks++; if (LO !== 32'd0)    begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
    rst = 1'b1; RHLRd = 1'b0;
    sb_q.push_back(model(2'd0, 32'd3, 32'd5));
    wait_done(1'b0, lat, nb, hi, lo, hl);
    exp = sb_q.pop_front();
    checks++; if (lat !== 33)         begin errors++; $display("FAIL first_start_latency got %0d want 33", lat); end
    checks++; if (hi !== exp[63:32])  begin errors++; $display("FAIL first_start_hi got %h want %h", hi, exp[63:32]); end
    checks++; if (lo !== exp[31:0])   begin errors++; $display("FAIL first_start_lo got %h want %h", lo, exp[31:0]); end
    last_hi = exp[63:32]; last_lo = exp[31:0];
  endtask

  task automatic test_ops;
    int lat, nb; logic [31:0] hi, lo; logic hl; logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      issue(v_op[i], v_a[i], v_b[i]);
      sb_q.push_back(model(v_op[i], v_a[i], v_b[i]));
      wait_done(v_fad[i], lat, nb, hi, lo, hl);
      exp = sb_q.pop_front();
      checks++; if (lat !== 33)         begin errors++; $display("FAIL ops[%0d]_latency got %0d want 33", i, lat); end
      checks++; if (nb !== 33)          begin errors++; $display("FAIL ops[%0d]_busy_cycles got %0d want 33", i, nb); end
      checks++; if (hi !== exp[63:32])  begin errors++; $display("FAIL ops[%0d]_hi got %h want %h", i, hi, exp[63:32]); end
      checks++; if (lo !== exp[31:0])   begin errors++; $display("FAIL ops[%0d]_lo got %h want %h", i, lo, exp[31:0]); end
      checks++; if (hl !== !v_fad[i])   begin errors++; $display("FAIL ops[%0d]_hlwr got %b want %b", i, hl, !v_fad[i]); end
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_flush;
    int lat, nb; logic [31:0] hi, lo; logic hl; logic [63:0] exp; bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    issue(2'd0, 32'd12345, 32'd678);
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
      if (n == 1)  start = 1'b0;
      if (n == 10) flush = 1'b1;
      if (n == 11) begin
        flush = 1'b0;
        issue(2'd2, 32'd1000, 32'd33);
        sb_q.push_back(model(2'd2, 32'd1000, 32'd33));
      end
      #1;
      if (done || HLWr) seen = 1'b1;
      if (n == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (HI !== last_hi) begin errors++; $display("FAIL flush_hi_hold got %h want %h", HI, last_hi); end
        checks++; if (LO !== last_lo) begin errors++; $display("FAIL flush_lo_hold got %h want %h", LO, last_lo); end
      end
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got %b want 0", seen); end
    wait_done(1'b0, lat, nb, hi, lo, hl);
    exp = sb_q.pop_front();
    checks++; if (lat !== 33)        begin errors++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
    checks++; if (hi !== exp[63:32]) begin errors++; $display("FAIL flush_restart_hi got %h want %h", hi, exp[63:32]); end
    checks++; if (lo !== exp[31:0])  begin errors++; $display("FAIL flush_restart_lo got %h want %h", lo, exp[31:0]); end
    checks++; if (hl !== 1'b1)       begin errors++; $display("FAIL flush_restart_hlwr got %b want 1", hl); end
    last_hi = exp[63:32]; last_lo = exp[31:0];
  endtask

  task automatic test_hazard;
    logic [63:0] exp; logic exp_stall;
    @(posedge clk); #1;
    RHLRd = 1'b1;
    issue(2'd2, 32'd1000, 32'd7);
    sb_q.push_back(model(2'd2, 32'd1000, 32'd7));
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hazard_idle_stall got %b want 0", stall); end
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start = 1'b0; RHLRd = 1'b0; end
      if (n == 2) RHLRd = 1'b1;
      if (n == 5) issue(2'd0, 32'd5, 32'd1);
      if (n == 6) start = 1'b0;
      #1;
      if (n >= 2 && n <= 34) begin
        exp_stall = (n <= 33);
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL hazard_stall[%0d] got %b want %b", n, stall, exp_stall); end
      end
      if (n == 33) begin
        exp = sb_q.pop_front();
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL hazard_done got %b want 1", done); end
        checks++; if (HI !== exp[63:32])  begin errors++; $display("FAIL hazard_hi got %h want %h", HI, exp[63:32]); end
        checks++; if (LO !== exp[31:0])   begin errors++; $display("FAIL hazard_lo got %h want %h", LO, exp[31:0]); end
        last_hi = exp[63:32]; last_lo = exp[31:0];
      end
      if (n > 33) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hazard_no_queue[%0d] got %b want 0", n, busy); end
      end
    end
    RHLRd = 1'b0;
  endtask

  task automatic test_reset_midop;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    issue(2'd1, 32'hFFFFFFFD, 32'd5);
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (n == 1)  start = 1'b0;
      if (n == 20) rst = 1'b0;
      #1;
      if (done || HLWr) seen = 1'b1;
      if (n == 21) begin
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b want 0", stall); end
        checks++; if (HI !== 32'd0)   begin errors++; $display("FAIL midreset_hi got %h want 0", HI); end
        checks++; if (LO !== 32'd0)   begin errors++; $display("FAIL midreset_lo got %h want 0", LO); end
        rst = 1'b1;
      end
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_hlwr got %b want 0", seen); end
    last_hi = 32'd0; last_lo = 32'd0;
  endtask

  task automatic test_back_to_back;
    int lat, nb; logic [31:0] hi, lo, a, b; logic hl; logic [63:0] exp; logic [1:0] op;
    for (int k = 0; k < 6; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (k == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      @(posedge clk); #1;
      issue(op, a, b);
      sb_q.push_back(model(op, a, b));
      wait_done(1'b0, lat, nb, hi, lo, hl);
      exp = sb_q.pop_front();
      checks++; if (lat !== 33)        begin errors++; $display("FAIL b2b[%0d]_latency got %0d want 33", k, lat); end
      checks++; if (hi !== exp[63:32]) begin errors++; $display("FAIL b2b[%0d]_hi op=%0d a=%h b=%h got %h want %h", k, op, a, b, hi, exp[63:32]); end
      checks++; if (lo !== exp[31:0])  begin errors++; $display("FAIL b2b[%0d]_lo op=%0d a=%h b=%h got %h want %h", k, op, a, b, lo, exp[31:0]); end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ALU2Op = 2'd0; A = 32'd0; B = 32'd0; flush = 1'b0; RHLRd = 1'b0;
    last_hi = 32'd0; last_lo = 32'd0;
    test_reset;
    test_ops;
    test_flush;
    test_hazard;
    test_reset_midop;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL expose exactly the ports in REQ-002 to REQ-014, one clock, with synchronous active-low reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 start  in  1  EX-stage multiply/divide issue request (decoder RHLWr qualified with ALU2Op mult/div).
REQ-005 ALU2Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 A  in  32  rs operand; dividend for divide.
REQ-007 B  in  32  rt operand; divisor for divide.
REQ-008 flush  in  1  pipeline flush from exception or eret; aborts an in-flight operation.
REQ-009 RHLRd  in  1  ID-stage instruction needs HI/LO (MFHI, MFLO, MTHI, MTLO, mult, div).
REQ-010 busy  out  1  operation in flight.
REQ-011 stall  out  1  pipeline hold request.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 HLWr  out  1  HI/LO register write enable for the result.
REQ-014 HI / LO  out  32 each  result: high product or remainder / low product or quotient.

Function
REQ-015 States SHALL be IDLE, CALC and DONE; busy = (state != IDLE).
REQ-016 IDLE: if start=1 and flush=0, latch the op, |A| and |B|, and the result sign flags, clear the iteration counter, and go to CALC.
REQ-017 Signed ops (MULT, DIV) SHALL use absolute values. The product sign is A[31]^B[31]. The quotient sign is A[31]^B[31]. The remainder sign follows A[31]. The final result SHALL be two's-complement negated when its sign flag is set.
REQ-018 Unsigned ops SHALL use the operands unmodified and never negate.
REQ-019 CALC SHALL perform exactly 32 iterations, one per cycle, using a 6-bit counter 0..31:
- multiply: radix-2 shift-add into a 64-bit accumulator.
- divide: restoring shift-subtract into a 64-bit remainder:quotient register.
REQ-020 When the counter reaches 31, the next edge SHALL go to DONE with HI/LO holding the final sign-corrected result.
REQ-021 In DONE, done=1 and HLWr=(flush==0). The next edge SHALL return to IDLE.
REQ-022 Latency: done/HLWr SHALL be high exactly 33 cycles after the cycle in which start was accepted. It is fixed for all ops and operand values.
REQ-023 Divide by zero (B=0) SHALL still take 33 cycles and SHALL produce LO=32'hFFFFFFFF and HI=A (raw operand, no sign correction).
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000, with no trap.
REQ-025 flush=1 in CALC SHALL force IDLE on the next edge with no done or HLWr; the counter is cleared.
REQ-026 flush=1 together with start in IDLE SHALL ignore start.
REQ-027 start=1 while busy SHALL be ignored (not queued); the issuing stage holds the instruction via stall.
REQ-028 stall = busy & (RHLRd | start), combinational.
REQ-029 stall SHALL be 0 in IDLE. In DONE, stall SHALL still assert so the dependent reader sees HI/LO after the write.
REQ-030 HI/LO SHALL hold their last completed values while IDLE. They change only on the DONE transition.

Reset
REQ-031 rst=0 at a rising edge SHALL force:
- state IDLE, counter 0;
- HI=0, LO=0, accumulator 0;
- busy=0, stall=0, done=0, HLWr=0.
REQ-032 Reset SHALL override everything, including mid-CALC operation and a simultaneous start; no HLWr follows a reset.
REQ-033 The first start SHALL be accepted on the first edge with rst=1.

Verification
REQ-034 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 33 cycles; then done=HLWr=1 for one cycle with HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 MULT A=0xFFFFFFFD(-3) B=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 at cycle 33; DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIVU A=100 B=0 -> cycle 33 LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 MULTU start, flush=1 at cycle 10 -> busy=0 from cycle 11, done/HLWr never assert, HI/LO unchanged; a new start at cycle 11 completes at cycle 44.
REQ-038 Hazard case: RHLRd=1 held from cycle 2 after DIVU start -> stall=1 through cycle 33 inclusive, stall=0 at cycle 34; a second start at cycle 5 is ignored.
REQ-039 Reset case: rst=0 at cycle 20 of a MULT -> next cycle all outputs 0 and state IDLE; no HLWr ever follows.
